// File: rtl/dmc_rx_frame_seq.sv
// -----------------------------------------------------------------------------
// dmc_rx_frame_seq
//   Per-lane receive-frame sequencer for one DMC decode lane. Waits for the
//   lane FIFO to reach a fill threshold, enables the decoder in clock phase,
//   hunts the sync word, switches to data phase, assembles a DATA_BITS word
//   (first bit in the MSB), reports the frame result and then holds the
//   decoder line reset for GAP_CYCLES cycles so the next frame starts clean.
//
// Ports
//   clk_i, reset        decode clock, asynchronous active-high reset
//   start, abort        arm one frame (IDLE only) / abandon the current frame
//   cfg_timeout         max cycles between bit strobes (0 = no timeout)
//   fifo_level/_threshold  FIFO occupancy gate for decode start
//   dec_*  (inputs)     decoder bit strobe, clock/data-phase bits, early-done
//   dec_enable, dec_clk_or_data, dec_line_rst_n, fifo_clr  decoder controls
//   frame_data, frame_done, frame_status, busy  frame results and status
// -----------------------------------------------------------------------------
module dmc_rx_frame_seq #(
    parameter logic [7:0] SYNC_PATTERN    = 8'b10101100,
    parameter int         SYNC_SEARCH_MAX = 32,
    parameter int         DATA_BITS       = 32,
    parameter int         TIMEOUT_W       = 12,
    parameter int         GAP_CYCLES      = 4
) (
    input  logic                 clk_i,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic [5:0]           fifo_level,
    input  logic [4:0]           fifo_threshold,
    input  logic                 dec_bit_stb,
    input  logic                 dec_sync,
    input  logic                 dec_data,
    input  logic                 dec_early_done,
    output logic                 dec_enable,
    output logic                 dec_clk_or_data,
    output logic                 dec_line_rst_n,
    output logic                 fifo_clr,
    output logic [DATA_BITS-1:0] frame_data,
    output logic                 frame_done,
    output logic [1:0]           frame_status,
    output logic                 busy
);

    localparam int SRCH_W = $clog2(SYNC_SEARCH_MAX + 1);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ARM, SYNC, DATA, DONE, GAP} state_e;
    typedef enum logic [1:0] {ST_OK, ST_NOSYNC, ST_EARLY, ST_TIMEOUT} status_e;

    state_e                state_q,      state_d;
    status_e               status_q,     status_d;
    logic [7:0]            sync_sr_q,    sync_sr_d;
    logic [SRCH_W-1:0]     search_q,     search_d;
    logic [DATA_BITS-1:0]  data_sr_q,    data_sr_d;
    logic [BIT_W-1:0]      bit_cnt_q,    bit_cnt_d;
    logic [TIMEOUT_W-1:0]  tmo_q,        tmo_d;
    logic [GAP_W-1:0]      gap_cnt_q,    gap_cnt_d;
    logic [DATA_BITS-1:0]  frame_data_q, frame_data_d;
    logic                  enable_q,     enable_d;
    logic                  cod_q,        cod_d;
    logic                  line_rst_n_q, line_rst_n_d;
    logic                  fifo_clr_q,   fifo_clr_d;
    logic                  done_q,       done_d;
    logic                  busy_q,       busy_d;

    logic                  fin;
    status_e               fin_code;

    // NOTE: every variable assigned here gets a default first, otherwise a
    // path that skips an assignment would infer a latch. Blocking '=' is
    // correct inside always_comb; the flops below use '<=' only.
    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        sync_sr_d    = sync_sr_q;
        search_d     = search_q;
        data_sr_d    = data_sr_q;
        bit_cnt_d    = bit_cnt_q;
        tmo_d        = tmo_q;
        gap_cnt_d    = gap_cnt_q;
        frame_data_d = frame_data_q;
        fifo_clr_d   = 1'b0;
        fin          = 1'b0;
        fin_code     = ST_OK;

        case (state_q)
            IDLE: begin
                sync_sr_d = '0;
                search_d  = '0;
                data_sr_d = '0;
                bit_cnt_d = '0;
                tmo_d     = '0;
                if (start) state_d = ARM;
            end
            ARM: begin
                if (fifo_level >= {1'b0, fifo_threshold}) begin
                    state_d = SYNC;
                    tmo_d   = cfg_timeout;
                end
            end
            SYNC: begin
                if (dec_bit_stb) begin
                    sync_sr_d = {sync_sr_q[6:0], dec_sync};
                    search_d  = search_q + 1'b1;
                    tmo_d     = cfg_timeout;
                    // Compare the updated window so the completing strobe
                    // matches in its own cycle; a match on the last allowed
                    // bit still wins over exhaustion.
                    if (sync_sr_d == SYNC_PATTERN) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        data_sr_d = '0;
                    end else if (search_d == SRCH_W'(SYNC_SEARCH_MAX)) begin
                        fin      = 1'b1;
                        fin_code = ST_NOSYNC;
                    end
                end else if (cfg_timeout != '0) begin
                    tmo_d = tmo_q - 1'b1;
                    if (tmo_q <= TIMEOUT_W'(1)) begin
                        fin      = 1'b1;
                        fin_code = ST_TIMEOUT;
                    end
                end
            end
            DATA: begin
                if (dec_bit_stb) begin
                    data_sr_d = {data_sr_q[DATA_BITS-2:0], dec_data};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    tmo_d     = cfg_timeout;
                end
                // A final strobe beats a coincident early-done.
                if (dec_bit_stb && bit_cnt_d == BIT_W'(DATA_BITS)) begin
                    fin          = 1'b1;
                    fin_code     = ST_OK;
                    frame_data_d = data_sr_d;
                end else if (dec_early_done) begin
                    fin      = 1'b1;
                    fin_code = ST_EARLY;
                end else if (!dec_bit_stb && cfg_timeout != '0) begin
                    tmo_d = tmo_q - 1'b1;
                    if (tmo_q <= TIMEOUT_W'(1)) begin
                        fin      = 1'b1;
                        fin_code = ST_TIMEOUT;
                    end
                end
            end
            DONE: begin
                state_d   = GAP;
                gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
            end
            GAP: begin
                if (gap_cnt_q == '0) state_d = IDLE;
                else                 gap_cnt_d = gap_cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            state_d    = DONE;
            status_d   = fin_code;
            fifo_clr_d = (fin_code != ST_OK);
        end

        // Abort outranks everything: drop any result computed this cycle.
        if (abort && state_q != IDLE) begin
            state_d      = GAP;
            gap_cnt_d    = GAP_W'(GAP_CYCLES - 1);
            fifo_clr_d   = 1'b1;
            status_d     = status_q;
            frame_data_d = frame_data_q;
        end

        // Outputs are decoded from the next state so they are registered yet
        // line up with the state they describe.
        enable_d     = (state_d == ARM) || (state_d == SYNC) || (state_d == DATA);
        cod_d        = (state_d == DATA);
        line_rst_n_d = (state_d != IDLE) && (state_d != GAP);
        done_d       = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            status_q     <= ST_OK;
            sync_sr_q    <= '0;
            search_q     <= '0;
            data_sr_q    <= '0;
            bit_cnt_q    <= '0;
            tmo_q        <= '0;
            gap_cnt_q    <= '0;
            frame_data_q <= '0;
            enable_q     <= 1'b0;
            cod_q        <= 1'b0;
            line_rst_n_q <= 1'b0;
            fifo_clr_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            sync_sr_q    <= sync_sr_d;
            search_q     <= search_d;
            data_sr_q    <= data_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_q        <= tmo_d;
            gap_cnt_q    <= gap_cnt_d;
            frame_data_q <= frame_data_d;
            enable_q     <= enable_d;
            cod_q        <= cod_d;
            line_rst_n_q <= line_rst_n_d;
            fifo_clr_q   <= fifo_clr_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign dec_enable      = enable_q;
    assign dec_clk_or_data = cod_q;
    assign dec_line_rst_n  = line_rst_n_q;
    assign fifo_clr        = fifo_clr_q;
    assign frame_data      = frame_data_q;
    assign frame_done      = done_q;
    assign frame_status    = status_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_dmc_rx_frame_seq.sv
// -----------------------------------------------------------------------------
// tb_dmc_rx_frame_seq
//   Directed bench for dmc_rx_frame_seq: a table of whole frames (data word,
//   bits sent, early-done usage, expected status/data) plus hand-written
//   sequences for sync miss, late sync match, timeouts, abort, ARM gating and
//   asynchronous reset. Inputs change and outputs are sampled 1 ns after
//   the rising edge.
// -----------------------------------------------------------------------------
module tb_dmc_rx_frame_seq;

    logic        clk_i = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] cfg_timeout = '0;
    logic [5:0]  fifo_level = '0;
    logic [4:0]  fifo_threshold = '0;
    logic        dec_bit_stb = 1'b0;
    logic        dec_sync = 1'b0;
    logic        dec_data = 1'b0;
    logic        dec_early_done = 1'b0;
    logic        dec_enable, dec_clk_or_data, dec_line_rst_n, fifo_clr;
    logic [31:0] frame_data;
    logic        frame_done;
    logic [1:0]  frame_status;
    logic        busy;

    dmc_rx_frame_seq dut (
        .clk_i          (clk_i),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .cfg_timeout    (cfg_timeout),
        .fifo_level     (fifo_level),
        .fifo_threshold (fifo_threshold),
        .dec_bit_stb    (dec_bit_stb),
        .dec_sync       (dec_sync),
        .dec_data       (dec_data),
        .dec_early_done (dec_early_done),
        .dec_enable     (dec_enable),
        .dec_clk_or_data(dec_clk_or_data),
        .dec_line_rst_n (dec_line_rst_n),
        .fifo_clr       (fifo_clr),
        .frame_data     (frame_data),
        .frame_done     (frame_done),
        .frame_status   (frame_status),
        .busy           (busy)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] word;
        int          n_bits;
        bit          early;
        logic [1:0]  exp_status;
        logic [31:0] exp_data;
    } frame_vec_t;

    frame_vec_t  vecs[5];
    logic [7:0]  sp = 8'b10101100;
    logic [31:0] last_good;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic strobe_bit(input logic s, input logic d, input logic e);
        dec_bit_stb    = 1'b1;
        dec_sync       = s;
        dec_data       = d;
        dec_early_done = e;
        step();
        dec_bit_stb    = 1'b0;
        dec_early_done = 1'b0;
    endtask

    // IDLE -> ARM -> SYNC (FIFO level already above threshold).
    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    // Sync word MSB first; phase must flip exactly on the 8th strobe.
    task automatic send_pattern();
        for (int i = 0; i < 8; i++) begin
            strobe_bit(sp[7-i], 1'b0, 1'b0);
            if (i == 6) check("phase_before_sync", {31'd0, dec_clk_or_data}, 32'd0);
            if (i < 7) step();
        end
        check("phase_after_sync", {31'd0, dec_clk_or_data}, 32'd1);
    endtask

    // Called while DONE is visible: line reset held 4 cycles, then IDLE.
    task automatic gap_check();
        int bad = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (busy !== 1'b1 || dec_line_rst_n !== 1'b0 || frame_done !== 1'b0 ||
                dec_enable !== 1'b0) bad++;
        end
        check("gap_hold", bad, 0);
        step();
        check("gap_to_idle", {30'd0, busy, dec_line_rst_n}, 32'd0);
    endtask

    task automatic abort_check();
        int bad = 0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_first_gap", {27'd0, fifo_clr, frame_done, busy, dec_line_rst_n, dec_enable},
              32'b10100);
        for (int k = 0; k < 3; k++) begin
            step();
            if (busy !== 1'b1 || fifo_clr !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        check("abort_gap_hold", bad, 0);
        step();
        check("abort_to_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'hA5C30F96, 32, 1'b0, 2'd0, 32'hA5C30F96};
        vecs[1] = '{32'h12345678, 10, 1'b1, 2'd2, 32'hA5C30F96};
        vecs[2] = '{32'hDEADBEEF, 32, 1'b1, 2'd0, 32'hDEADBEEF};
        vecs[3] = '{32'h80000000,  0, 1'b1, 2'd2, 32'hDEADBEEF};
        vecs[4] = '{32'h00000001, 32, 1'b0, 2'd0, 32'h00000001};

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_ctrl", {25'd0, busy, dec_enable, dec_line_rst_n, dec_clk_or_data,
              fifo_clr, frame_done, frame_status}, 32'd0);
        check("reset_data", frame_data, 32'd0);
        #2 reset = 1'b0;
        step();
        check("idle_after_reset", {30'd0, busy, dec_line_rst_n}, 32'd0);

        fifo_threshold = 5'd3;
        fifo_level     = 6'd3;
        cfg_timeout    = 12'd100;

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            check("arm_outputs", {29'd0, dec_enable, dec_line_rst_n, busy}, 32'b111);
            step();
            send_pattern();
            for (int b = 0; b < vecs[v].n_bits; b++) begin
                strobe_bit(1'b0, vecs[v].word[31-b],
                           vecs[v].early && (vecs[v].n_bits == 32) && (b == 31));
                if (b < vecs[v].n_bits - 1) step();
            end
            if (vecs[v].early && vecs[v].n_bits < 32) begin
                dec_early_done = 1'b1;
                step();
                dec_early_done = 1'b0;
            end
            check("frame_done", {31'd0, frame_done}, 32'd1);
            check("frame_status", {30'd0, frame_status}, {30'd0, vecs[v].exp_status});
            check("frame_fifo_clr", {31'd0, fifo_clr}, {31'd0, vecs[v].exp_status != 2'd0});
            check("frame_data", frame_data, vecs[v].exp_data);
            gap_check();
        end
        last_good = 32'h00000001;

        // Sync miss: 32 ones never match
        start_frame();
        for (int i = 0; i < 32; i++) begin
            strobe_bit(1'b1, 1'b0, 1'b0);
            if (i == 30) check("nosync_pending", {30'd0, frame_done, busy}, 32'b01);
            if (i < 31) step();
        end
        check("nosync_done", {28'd0, frame_done, fifo_clr, frame_status}, 32'b1101);
        check("nosync_data_held", frame_data, last_good);
        gap_check();

        // Match on the 32nd (last allowed) bit succeeds, then abort mid-DATA
        start_frame();
        for (int i = 0; i < 24; i++) begin
            strobe_bit(1'b1, 1'b0, 1'b0);
            step();
        end
        send_pattern();
        check("late_sync_no_done", {30'd0, frame_done, busy}, 32'b01);
        for (int b = 0; b < 5; b++) begin
            strobe_bit(1'b0, 1'b1, 1'b0);
            step();
        end
        abort_check();
        check("abort_data_held", frame_data, last_good);

        // Timeout: frame_done 20 cycles after the last strobe
        cfg_timeout = 12'd20;
        start_frame();
        send_pattern();
        for (int b = 0; b < 3; b++) begin
            strobe_bit(1'b0, 1'b1, 1'b0);
            if (b < 2) step();
        end
        repeat (19) step();
        check("tmo_not_yet", {31'd0, frame_done}, 32'd0);
        step();
        check("tmo_done", {28'd0, frame_done, fifo_clr, frame_status}, 32'b1111);
        check("tmo_data_held", frame_data, last_good);
        gap_check();

        // Strobe on the expiry cycle reloads the counter
        start_frame();
        send_pattern();
        for (int b = 0; b < 3; b++) begin
            strobe_bit(1'b0, 1'b0, 1'b0);
            if (b < 2) step();
        end
        repeat (19) step();
        strobe_bit(1'b0, 1'b1, 1'b0);
        check("tmo_rescued", {30'd0, frame_done, busy}, 32'b01);
        repeat (19) step();
        check("tmo_reloaded_wait", {31'd0, frame_done}, 32'd0);
        step();
        check("tmo_after_reload", {29'd0, frame_done, frame_status}, 32'b111);
        gap_check();

        // cfg_timeout = 0 disables the timeout
        cfg_timeout = 12'd0;
        start_frame();
        send_pattern();
        strobe_bit(1'b0, 1'b1, 1'b0);
        step();
        strobe_bit(1'b0, 1'b0, 1'b0);
        begin
            int seen = 0;
            repeat (200) begin
                step();
                if (frame_done !== 1'b0) seen++;
            end
            check("no_tmo_done", seen, 0);
        end
        check("no_tmo_busy", {30'd0, busy, dec_clk_or_data}, 32'b11);
        abort_check();

        // ARM gating, then asynchronous reset mid-SYNC
        cfg_timeout = 12'd100;
        fifo_level  = 6'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        check("arm_hold", {28'd0, dec_enable, busy, dec_clk_or_data, dec_line_rst_n}, 32'b1101);
        fifo_level = 6'd3;
        step();
        strobe_bit(1'b1, 1'b0, 1'b0);
        step();
        strobe_bit(1'b0, 1'b0, 1'b0);
        check("pre_reset_data", frame_data, last_good);
        #2 reset = 1'b1;
        #1;
        check("async_reset_ctrl", {25'd0, busy, dec_enable, dec_line_rst_n, dec_clk_or_data,
              fifo_clr, frame_done, frame_status}, 32'd0);
        check("async_reset_data", frame_data, 32'd0);
        #3 reset = 1'b0;
        step();
        step();
        check("post_reset_idle", {30'd0, busy, frame_done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
